// File: rtl/frac_div_pkg.sv
// ---------------------------------------------------------------------------
// frac_div_pkg
//   Shared definitions for the fractional restoring divider:
//     - state_t     : controller states (IDLE, RUN, FIX, DONE)
//     - div_latency : start-to-ready latency in cycles for given NI/NF
//     - cnt_width   : width of the iteration counter for given NI/NF
//     - CNT_W       : counter width for the default 8.8 configuration
// ---------------------------------------------------------------------------
package frac_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_NI = 8;
  localparam int DEF_NF = 8;

  // One cycle per quotient bit plus one cycle of sign fix-up.
  function automatic int div_latency(input int ni, input int nf);
    return ni + nf + 1;
  endfunction

  // The counter is loaded with N and counts down to 0.
  function automatic int cnt_width(input int ni, input int nf);
    return $clog2(ni + nf + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_NI, DEF_NF);

endpackage

// File: rtl/frac_div_step.sv
// ---------------------------------------------------------------------------
// frac_div_step
//   One combinational restoring-division iteration.
//   Ports:
//     prem_i    [NI:0]   current partial remainder (always < divisor)
//     divisor_i [NI-1:0] divisor magnitude
//     bit_i              next working-dividend bit (MSB first)
//     prem_o    [NI:0]   next partial remainder
//     qbit_o             quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module frac_div_step
  import frac_div_pkg::*;
#(
  parameter int NI = DEF_NI
) (
  input  logic [NI:0]   prem_i,
  input  logic [NI-1:0] divisor_i,
  input  logic          bit_i,
  output logic [NI:0]   prem_o,
  output logic          qbit_o
);

  logic [NI:0]   shifted;
  logic [NI+1:0] diff;

  // The incoming remainder is below the divisor, so it fits in NI bits and
  // the shifted value never loses its top bit.
  assign shifted = {prem_i[NI-1:0], bit_i};

  // One extra guard bit: its value is the borrow of the trial subtraction.
  assign diff = {1'b0, shifted} - {2'b00, divisor_i};

  assign qbit_o = ~diff[NI+1];
  assign prem_o = qbit_o ? diff[NI:0] : shifted;

endmodule

// File: rtl/frac_divider.sv
// ---------------------------------------------------------------------------
// frac_divider
//   Multi-cycle restoring divider producing an NI.NF fixed-point quotient
//   and an NI-bit integer remainder, with runtime signed/unsigned mode.
//   Ports:
//     clk, reset           rising-edge clock, synchronous active-high reset
//     start                request, accepted only in IDLE/DONE
//     is_signed            1 = two's-complement operands and results
//     dividend, divisor    NI-bit operands, latched on accepted start
//     Q                    NI+NF-bit quotient (NI.NF fixed point)
//     remainder            dividend*2^NF - Q*divisor
//     ready                result valid (held in DONE)
//     busy                 division in progress (RUN/FIX)
//     div_by_zero          divisor was zero
//     overflow             signed quotient not representable (saturated)
// ---------------------------------------------------------------------------
module frac_divider
  import frac_div_pkg::*;
#(
  parameter int NI = DEF_NI,
  parameter int NF = DEF_NF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [NI-1:0]    dividend,
  input  logic [NI-1:0]    divisor,
  output logic [NI+NF-1:0] Q,
  output logic [NI-1:0]    remainder,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N  = NI + NF;
  localparam int CW = cnt_width(NI, NF);

  // Magnitude of an operand; in signed mode -2^(NI-1) maps to 2^(NI-1),
  // which still fits NI unsigned bits.
  function automatic logic [NI-1:0] magnitude(input logic [NI-1:0] x,
                                              input logic          sgn);
    return (sgn && x[NI-1]) ? (~x + 1'b1) : x;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   work_q, work_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [NI:0]    prem_q, prem_d;
  logic [NI-1:0]  dvsr_q, dvsr_d;
  logic [NI-1:0]  dvnd_q, dvnd_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
  logic           signed_q, signed_d;
  logic           dbz_pend_q, dbz_pend_d;

  logic [N-1:0]   q_out_q, q_out_d;
  logic [NI-1:0]  rem_out_q, rem_out_d;
  logic           ready_q, ready_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;

  logic [NI:0]    step_prem;
  logic           step_qbit;

  frac_div_step #(.NI(NI)) u_step (
    .prem_i    (prem_q),
    .divisor_i (dvsr_q),
    .bit_i     (work_q[N-1]),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    quo_d      = quo_q;
    prem_d     = prem_q;
    dvsr_d     = dvsr_q;
    dvnd_d     = dvnd_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    signed_d   = signed_q;
    dbz_pend_d = dbz_pend_q;
    q_out_d    = q_out_q;
    rem_out_d  = rem_out_q;
    ready_d    = ready_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          cnt_d      = CW'(N);
          // Working dividend is |dividend| scaled by 2^NF.
          work_d     = N'(magnitude(dividend, is_signed)) << NF;
          quo_d      = '0;
          prem_d     = '0;
          dvsr_d     = magnitude(divisor, is_signed);
          dvnd_d     = dividend;
          signed_d   = is_signed;
          q_neg_d    = is_signed & (dividend[NI-1] ^ divisor[NI-1]);
          r_neg_d    = is_signed & dividend[NI-1];
          dbz_pend_d = (divisor == '0);
          ready_d    = 1'b0;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
        end
      end

      ST_RUN: begin
        // Iteration keeps running on a zero divisor so latency is constant;
        // the result is replaced in FIX.
        prem_d = step_prem;
        quo_d  = {quo_q[N-2:0], step_qbit};
        work_d = work_q << 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_DONE;
        ready_d = 1'b1;
        if (dbz_pend_q) begin
          q_out_d   = '1;
          rem_out_d = dvnd_q;
          dbz_d     = 1'b1;
          ovf_d     = 1'b0;
        end else if (signed_q && !q_neg_q && quo_q[N-1]) begin
          // Positive result with magnitude 2^(N-1): only -2^(NI-1)/-1.
          q_out_d   = {1'b0, {(N-1){1'b1}}};
          rem_out_d = '0;
          dbz_d     = 1'b0;
          ovf_d     = 1'b1;
        end else begin
          q_out_d   = q_neg_q ? (~quo_q + 1'b1) : quo_q;
          // Remainder follows the dividend sign (truncation toward zero).
          rem_out_d = r_neg_q ? (~prem_q[NI-1:0] + 1'b1) : prem_q[NI-1:0];
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      quo_q      <= '0;
      prem_q     <= '0;
      dvsr_q     <= '0;
      dvnd_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      signed_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      q_out_q    <= '0;
      rem_out_q  <= '0;
      ready_q    <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      quo_q      <= quo_d;
      prem_q     <= prem_d;
      dvsr_q     <= dvsr_d;
      dvnd_q     <= dvnd_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      signed_q   <= signed_d;
      dbz_pend_q <= dbz_pend_d;
      q_out_q    <= q_out_d;
      rem_out_q  <= rem_out_d;
      ready_q    <= ready_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Q           = q_out_q;
  assign remainder   = rem_out_q;
  assign ready       = ready_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_frac_divider.sv
// ---------------------------------------------------------------------------
// tb_frac_divider
//   Directed vectors for the 8.8 divider. Each accepted start pushes its
//   hand-computed result into a scoreboard queue; a monitor pops and checks
//   on every rising edge of ready, including start-to-ready latency.
// ---------------------------------------------------------------------------
module tb_frac_divider;

  localparam int NI  = 8;
  localparam int NF  = 8;
  localparam int LAT = NI + NF + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          is_signed;
  logic [NI-1:0] dividend;
  logic [NI-1:0] divisor;
  logic [15:0]   Q;
  logic [7:0]    remainder;
  logic          ready;
  logic          busy;
  logic          div_by_zero;
  logic          overflow;

  frac_divider #(.NI(NI), .NF(NF)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .Q           (Q),
    .remainder   (remainder),
    .ready       (ready),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   applied     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   txn         = 0;
  logic ready_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: exclusivity every cycle, scoreboard check on each new result.
  always @(negedge clk) begin
    exp_t e;
    if (busy && ready) begin
      miscompares++;
      $display("FAIL busy_ready_excl: busy=1 ready=1 at cycle %0d", cyc);
    end
    if (ready && !ready_prev) begin
      if (sb.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_ready: actual=result required=none");
      end else begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: Q=0x%04h rem=0x%02h dbz=%0b ovf=%0b lat=%0d",
                 txn, Q, remainder, div_by_zero, overflow,
                 cyc - e.start_cyc - 1);
        chk("Q", 32'(Q), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("latency", 32'(cyc - e.start_cyc - 1), 32'(LAT));
      end
    end
    ready_prev = ready;
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
    end
    if (i == 3 * LAT) begin
      applied++;
      miscompares++;
      $display("FAIL ready_timeout: actual=no ready required=ready within %0d", 3 * LAT);
    end
  endtask

  // Called at a negedge: issue one start pulse and push the expectation.
  task automatic issue(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er,
                       input logic edbz, input logic eovf);
    exp_t e;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf; e.start_cyc = cyc;
    sb.push_back(e);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er,
                       input logic edbz, input logic eovf);
    issue(sgn, a, b, eq, er, edbz, eovf);
    wait_ready();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_Q", 32'(Q), 32'h0);
    chk("rst_rem", 32'(remainder), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // Consecutive runs start on the first DONE cycle (back-to-back).
    do_op(1'b0, 8'd100, 8'd7,   16'h0E49, 8'h01, 1'b0, 1'b0);
    do_op(1'b1, 8'h9C,  8'd7,   16'hF1B7, 8'hFF, 1'b0, 1'b0);
    do_op(1'b1, 8'd7,   8'hFE,  16'hFC80, 8'h00, 1'b0, 1'b0);
    do_op(1'b1, 8'h80,  8'hFF,  16'h7FFF, 8'h00, 1'b0, 1'b1);
    do_op(1'b0, 8'h80,  8'hFF,  16'h0080, 8'h80, 1'b0, 1'b0);
    do_op(1'b0, 8'd55,  8'd0,   16'hFFFF, 8'h37, 1'b1, 1'b0);
    do_op(1'b1, 8'd100, 8'hF9,  16'hF1B7, 8'h01, 1'b0, 1'b0);
    do_op(1'b1, 8'h9C,  8'hF9,  16'h0E49, 8'hFF, 1'b0, 1'b0);
    do_op(1'b1, 8'h80,  8'd1,   16'h8000, 8'h00, 1'b0, 1'b0);
    do_op(1'b1, 8'hFD,  8'd0,   16'hFFFF, 8'hFD, 1'b1, 1'b0);
    do_op(1'b0, 8'd1,   8'd3,   16'h0055, 8'h01, 1'b0, 1'b0);
    do_op(1'b0, 8'd0,   8'd9,   16'h0000, 8'h00, 1'b0, 1'b0);

    // Second start mid-run must be ignored.
    issue(1'b0, 8'd255, 8'd1, 16'hFF00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    is_signed = 1'b1;
    dividend  = 8'd10;
    divisor   = 8'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready();

    // Reset at cycle 8 of a run aborts it; no result expected.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 8'd13;
    divisor   = 8'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ready", 32'(ready), 32'h0);
    chk("abort_Q", 32'(Q), 32'h0);
    chk("abort_rem", 32'(remainder), 32'h0);
    repeat (LAT + 2) @(negedge clk);
    chk("abort_no_result", 32'(ready), 32'h0);

    do_op(1'b0, 8'd200, 8'd3, 16'h42AA, 8'h02, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
